// File: rtl/mem_write_checker.sv
// Run controller that resets a processor top, then checks its data-memory writes against an ordered table.
// Optional build macro: MEMCHK_IGNORE_UNMATCHED_EN (skip writes whose address differs from the expected one).
module mem_write_checker #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 1000,
  parameter int RST_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx,
  input  logic [WIDTH-1:0]           exp_adr,
  input  logic [WIDTH-1:0]           exp_data,
  input  logic [$clog2(DEPTH+1)-1:0] exp_num,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  output logic                       dut_reset,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [$clog2(DEPTH+1)-1:0] match_count,
  output logic [2:0]                 dbg_state
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int RW = $clog2(RST_CYCLES+1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_DUT = 3'd1,
    S_RUN       = 3'd2,
    S_PASS      = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   exp_num_q, exp_num_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   match_count_q, match_count_d;
  logic [IW-1:0]   fail_idx_q, fail_idx_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic            dut_reset_q, dut_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;

  // Expected-write table; deliberately untouched by reset so a run can be repeated after a reset.
  logic [WIDTH-1:0] tbl_adr_q  [DEPTH];
  logic [WIDTH-1:0] tbl_data_q [DEPTH];

  logic          tbl_open;
  logic          adr_hit, data_hit, skip_write;
  logic [CW-1:0] exp_num_clamped;

  assign tbl_open = (state_q == S_IDLE) || (state_q == S_PASS) || (state_q == S_FAIL);

  always_ff @(posedge clk) begin
    if (reset && exp_we && tbl_open) begin
      tbl_adr_q[exp_idx]  <= exp_adr;
      tbl_data_q[exp_idx] <= exp_data;
    end
  end

  assign adr_hit  = (dataadr == tbl_adr_q[ptr_q]);
  assign data_hit = (writedata == tbl_data_q[ptr_q]);
  assign exp_num_clamped = (exp_num > CW'(DEPTH)) ? CW'(DEPTH) : exp_num;

`ifdef MEMCHK_IGNORE_UNMATCHED_EN
  assign skip_write = !adr_hit;
`else
  assign skip_write = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    exp_num_d     = exp_num_q;
    ptr_d         = ptr_q;
    match_count_d = match_count_q;
    fail_idx_d    = fail_idx_q;
    cnt_d         = cnt_q;
    rst_cnt_d     = rst_cnt_q;
    dut_reset_d   = dut_reset_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_d       = S_RESET_DUT;
          exp_num_d     = exp_num_clamped;
          ptr_d         = '0;
          match_count_d = '0;
          fail_idx_d    = '0;
          timeout_d     = 1'b0;
          cnt_d         = '0;
          rst_cnt_d     = '0;
          dut_reset_d   = 1'b1;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
        end
      end
      S_RESET_DUT: begin
        if (rst_cnt_q == RW'(RST_CYCLES-1)) begin
          if (exp_num_q == '0) begin
            state_d = S_PASS;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d     = S_RUN;
            dut_reset_d = 1'b0;
          end
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      S_RUN: begin
        // A write always takes priority over the timeout check in the same cycle.
        if (memwrite && adr_hit && data_hit) begin
          ptr_d         = ptr_q + IW'(1);
          match_count_d = match_count_q + CW'(1);
          cnt_d         = '0;
          if ((match_count_q + CW'(1)) == exp_num_q) begin
            state_d     = S_PASS;
            dut_reset_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = 1'b1;
          end
        end else if (memwrite && !skip_write) begin
          state_d     = S_FAIL;
          fail_idx_d  = ptr_q;
          dut_reset_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (cnt_q == TW'(TIMEOUT-1)) begin
          state_d     = S_FAIL;
          fail_idx_d  = ptr_q;
          timeout_d   = 1'b1;
          dut_reset_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      exp_num_q     <= '0;
      ptr_q         <= '0;
      match_count_q <= '0;
      fail_idx_q    <= '0;
      cnt_q         <= '0;
      rst_cnt_q     <= '0;
      dut_reset_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_num_q     <= exp_num_d;
      ptr_q         <= ptr_d;
      match_count_q <= match_count_d;
      fail_idx_q    <= fail_idx_d;
      cnt_q         <= cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      dut_reset_q   <= dut_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
    end
  end

  assign dut_reset   = dut_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_idx    = fail_idx_q;
  assign match_count = match_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: vector table of two-write runs plus hand-written timing sequences.
module tb_mem_write_checker;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             exp_we = 1'b0;
  logic [2:0]       exp_idx = '0;
  logic [WIDTH-1:0] exp_adr = '0;
  logic [WIDTH-1:0] exp_data = '0;
  logic [3:0]       exp_num = '0;
  logic             memwrite = 1'b0;
  logic [WIDTH-1:0] dataadr = '0;
  logic [WIDTH-1:0] writedata = '0;
  logic             dut_reset, busy, done, pass, timeout;
  logic [2:0]       fail_idx;
  logic [3:0]       match_count;
  logic [2:0]       dbg_state;

  mem_write_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(20), .RST_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_adr(exp_adr), .exp_data(exp_data), .exp_num(exp_num), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .dut_reset(dut_reset), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .fail_idx(fail_idx),
    .match_count(match_count), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_status(input logic d, input logic p, input logic t,
                                              input logic r, input logic [2:0] fi,
                                              input logic [3:0] mc);
    return {21'd0, d, p, t, r, fi, mc};
  endfunction

  // Driver tasks; every task starts and ends just after a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [2:0] idx, input logic [31:0] adr, input logic [31:0] data);
    exp_we = 1'b1; exp_idx = idx; exp_adr = adr; exp_data = data;
    step();
    exp_we = 1'b0;
  endtask

  task automatic write(input logic [31:0] adr, input logic [31:0] data);
    memwrite = 1'b1; dataadr = adr; writedata = data;
    step();
    memwrite = 1'b0;
  endtask

  // Start sampled at edge n; returns in the first RUN cycle (n+4 with three reset cycles).
  task automatic start_run(input logic [3:0] num, input bit poke);
    start = 1'b1; exp_num = num;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_dut_reset", dut_reset, 1);
    check("start_done_clr", done, 0);
    step();
    if (poke) write(32'h54, 32'h7);
    else step();
    check("rst_hold_dut_reset", dut_reset, 1);
    check("rst_hold_mc", match_count, 0);
    step();
    if (num != 0) check("run_entry_dut_reset", dut_reset, 0);
  endtask

  typedef struct {
    bit          stray;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  mid;
    logic        done, pass;
    logic [2:0]  fi;
    logic [3:0]  mc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 32'h54, 32'h7, 32'h58, 32'h7, 4'd1, 1, 1, 3'd0, 4'd2};
    vecs[1] = '{0, 32'h54, 32'h7, 32'h58, 32'h8, 4'd1, 1, 0, 3'd1, 4'd1};
    vecs[2] = '{0, 32'h54, 32'h8, 32'h58, 32'h7, 4'd0, 1, 0, 3'd0, 4'd0};
`ifdef MEMCHK_IGNORE_UNMATCHED_EN
    vecs[3] = '{1, 32'h54, 32'h7, 32'h58, 32'h7, 4'd1, 1, 1, 3'd0, 4'd2};
    vecs[4] = '{1, 32'h54, 32'h7, 32'h58, 32'h9, 4'd1, 1, 0, 3'd1, 4'd1};
`else
    vecs[3] = '{1, 32'h54, 32'h7, 32'h58, 32'h7, 4'd0, 1, 0, 3'd0, 4'd0};
    vecs[4] = '{1, 32'h54, 32'h7, 32'h58, 32'h9, 4'd0, 1, 0, 3'd0, 4'd0};
`endif

    // Reset values
    step(); step();
    check("rst_dut_reset", dut_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_fail_idx", fail_idx, 0);
    check("rst_match_count", match_count, 0);
    reset = 1'b1;
    step();
    load(3'd0, 32'h54, 32'h7);
    load(3'd1, 32'h58, 32'h7);

    // Vector table: writes at RUN+3 and RUN+5, optional stray 0x7FFC:3 at RUN+1
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'(vecs[i].mid));
      exp_q.push_back(pack_status(vecs[i].done, vecs[i].pass, 1'b0, vecs[i].done,
                                  vecs[i].fi, vecs[i].mc));
      start_run(4'd2, (i == 0));
      if (vecs[i].stray) begin
        step();
        write(32'h7FFC, 32'h3);
        step();
      end else begin
        step(); step(); step();
      end
      write(vecs[i].a0, vecs[i].d0);
      check($sformatf("vec%0d_mid_mc", i), match_count, exp_q.pop_front());
      step();
      write(vecs[i].a1, vecs[i].d1);
      check($sformatf("vec%0d_status", i),
            pack_status(done, pass, timeout, dut_reset, fail_idx, match_count), exp_q.pop_front());
    end

    // exp_num=0 goes straight to PASS after the reset phase
    start_run(4'd0, 0);
    check("zero_num_status", pack_status(done, pass, timeout, dut_reset, fail_idx, match_count),
          pack_status(1, 1, 0, 1, 3'd0, 4'd0));
    check("zero_num_busy", busy, 0);

    // Timeout exactly 20 cycles into RUN
    start_run(4'd2, 0);
    repeat (19) step();
    check("to_not_yet", done, 0);
    step();
    check("to_status", pack_status(done, pass, timeout, dut_reset, fail_idx, match_count),
          pack_status(1, 0, 1, 1, 3'd0, 4'd0));

    // Write in the timeout cycle wins and restarts the count
    start_run(4'd2, 0);
    repeat (19) step();
    write(32'h54, 32'h7);
    check("tie_mc", match_count, 1);
    check("tie_done", done, 0);
    repeat (19) step();
    check("tie_to_not_yet", done, 0);
    step();
    check("tie_to_status", pack_status(done, pass, timeout, dut_reset, fail_idx, match_count),
          pack_status(1, 0, 1, 1, 3'd1, 4'd1));

    // Back-to-back writes, then a write in PASS is ignored
    load(3'd2, 32'h60, 32'hA);
    load(3'd3, 32'h64, 32'hB);
    start_run(4'd4, 0);
    write(32'h54, 32'h7);
    write(32'h58, 32'h7);
    write(32'h60, 32'hA);
    write(32'h64, 32'hB);
    check("b2b_status", pack_status(done, pass, timeout, dut_reset, fail_idx, match_count),
          pack_status(1, 1, 0, 1, 3'd0, 4'd4));
    write(32'h68, 32'h0);
    check("pass_write_ignored_mc", match_count, 4);
    check("pass_write_ignored_pass", pass, 1);

    // Table write during RUN ignored; reset mid-run; rerun with retained table
    start_run(4'd2, 1);
    load(3'd1, 32'h58, 32'h9);
    write(32'h54, 32'h7);
    check("mid_mc", match_count, 1);
    reset = 1'b0;
    step();
    check("midrst_status", pack_status(done, pass, timeout, dut_reset, fail_idx, match_count),
          pack_status(0, 0, 0, 1, 3'd0, 4'd0));
    check("midrst_busy", busy, 0);
    check("midrst_state_idle", dbg_state, 0);
    reset = 1'b1;
    step();
    start_run(4'd2, 0);
    step();
    write(32'h54, 32'h7);
    step();
    write(32'h58, 32'h7);
    check("rerun_status", pack_status(done, pass, timeout, dut_reset, fail_idx, match_count),
          pack_status(1, 1, 0, 1, 3'd0, 4'd2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Self-checking run controller for processor-top simulations and FPGA bring-up. It drives the reset of the processor top, watches the data-memory write port (memwrite, dataadr, writedata), and compares each write against a preloaded, ordered table of expected writes. It reports pass, fail or timeout with diagnostic counters. It replaces ad-hoc fixed-delay reset pulses and free-running benches with a synthesizable, parametrised checker that can be reused across processor variants.

## Interface
- WIDTH, 32, width of address and data buses
- DEPTH, 8, maximum number of expected writes in the table
- TIMEOUT, 1000, max cycles in RUN without an accepted write before failing
- RST_CYCLES, 2, cycles dut_reset is held high after start (min 1)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low checker reset
- start  in  1  begin a run; level sampled each cycle
- exp_we  in  1  write expected-table entry
- exp_idx  in  $clog2(DEPTH)  table entry index
- exp_adr  in  WIDTH  expected address
- exp_data  in  WIDTH  expected data
- exp_num  in  $clog2(DEPTH+1)  number of entries to check; sampled on start
- memwrite  in  1  DUT memory write strobe
- dataadr  in  WIDTH  DUT write address
- writedata  in  WIDTH  DUT write data
- dut_reset  out  1  active-high reset to the processor top
- busy  out  1  run in progress (RESET_DUT or RUN)
- done  out  1  run finished (PASS or FAIL)
- pass  out  1  run finished with all writes matched
- timeout  out  1  failure was caused by timeout
- fail_idx  out  $clog2(DEPTH)  table index at the point of failure
- match_count  out  $clog2(DEPTH+1)  writes matched so far

## Operation
- FSM states: IDLE, RESET_DUT, RUN, PASS, FAIL.
- IDLE:
  - exp_we writes {exp_adr, exp_data} into table[exp_idx].
  - When start=1, latch exp_num, clear ptr, match_count, fail_idx, timeout and the cycle counter, then go to RESET_DUT.
- RESET_DUT:
  - dut_reset=1 for exactly RST_CYCLES cycles; memwrite is ignored.
  - Then go to RUN, or to PASS if the latched exp_num=0.
- RUN: dut_reset=0. On memwrite=1, compare {dataadr, writedata} with table[ptr].
  - Match: ptr and match_count increment and the cycle counter clears. When match_count reaches exp_num, go to PASS.
  - Mismatch: go to FAIL with fail_idx=ptr.
- Timeout: if the cycle counter reaches TIMEOUT while in RUN, go to FAIL with timeout=1 and fail_idx=ptr.
- PASS and FAIL:
  - Hold dut_reset=1 (halts the DUT) and done=1. pass=1 only in PASS.
  - start=1 restarts the run: go to RESET_DUT, clear the status outputs, reuse the table, and latch a new exp_num.
- exp_we is ignored outside IDLE, PASS and FAIL.
- start is ignored in RESET_DUT and RUN.
- The table is not cleared by reset; contents persist until overwritten.
- exp_num > DEPTH is clamped to DEPTH.

## Timing
- Reset (reset=0 at an edge) forces, on the next cycle, regardless of state or mid-run:
  - state IDLE
  - dut_reset=1
  - busy=0, done=0, pass=0, timeout=0
  - fail_idx=0, match_count=0
- start sampled at edge n: busy=1 and dut_reset=1 from cycle n+1. RUN is entered at cycle n+1+RST_CYCLES.
- A write sampled at edge m: match_count, or done/pass/fail_idx, update at cycle m+1. There is no combinational path from DUT inputs to outputs.
- The last matching write at edge m gives done=1, pass=1 and dut_reset=1 at cycle m+1.
- Writes are compared one per cycle; back-to-back memwrite on consecutive cycles must all be checked.
- If memwrite arrives in the same cycle the timeout count is reached, the write wins: it is evaluated and the counter clears.
- memwrite while in PASS or FAIL is ignored and not counted.

## Configuration
- MEMCHK_IGNORE_UNMATCHED_EN:
  - Defined: in RUN, a write whose dataadr differs from table[ptr].adr is ignored, does not fail the run, and does not clear the timeout counter. Only an address match with a data mismatch fails. Use this for programs with stack or scratch writes.
  - Undefined: any write differing in address or data fails immediately.

## Test plan
- Load table {0x54:7, 0x58:7}, exp_num=2, start; drive matching writes at RUN+3 and RUN+5 -> match_count=1 then 2; done=pass=1 and dut_reset=1 one cycle after the second write.
- Same table; second write is 0x58:8 -> FAIL, done=1, pass=0, fail_idx=1, match_count=1, timeout=0.
- Same table, TIMEOUT=20, no writes after RESET_DUT -> FAIL exactly 20 cycles into RUN, timeout=1, fail_idx=0.
- With MEMCHK_IGNORE_UNMATCHED_EN, insert write 0x7FFC:3 before the expected writes -> PASS; without the macro -> FAIL with fail_idx=0.
- Pull reset low during RUN after one match -> next cycle all outputs at reset values, dut_reset=1. Then start again -> the run passes using the retained table.
- RST_CYCLES=3: start at edge n -> dut_reset high for cycles n+1..n+3, low at n+4; memwrite=1 during n+2 is ignored (match_count stays 0).
